// File: rtl/branch_stage.sv
// Execute-to-Branch pipeline register with branch/JAL/JALR resolution.
// Redirect select and target are combinational from the B registers; redirects are counted.
module branch_stage #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             FlushB,
  input  logic             ValidE,
  input  logic [XLEN-1:0]  PCE,
  input  logic [XLEN-1:0]  PCPlus4E,
  input  logic [XLEN-1:0]  ImmExtE,
  input  logic [XLEN-1:0]  SrcAE,
  input  logic [XLEN-1:0]  SrcBE,
  input  logic [XLEN-1:0]  ALUResultE,
  input  logic [XLEN-1:0]  WriteDataE,
  input  logic [4:0]       RdE,
  input  logic             RegWriteE,
  input  logic [2:0]       ResultSrcE,
  input  logic             MemWriteE,
  input  logic             BranchE,
  input  logic             JumpE,
  input  logic             JalrE,
  input  logic [2:0]       Funct3E,
  output logic             ValidB,
  output logic [XLEN-1:0]  ALUResultB,
  output logic [XLEN-1:0]  WriteDataB,
  output logic [XLEN-1:0]  PCPlus4B,
  output logic [4:0]       RdB,
  output logic             RegWriteB,
  output logic [2:0]       ResultSrcB,
  output logic             MemWriteB,
  output logic [1:0]       PCSrcB,
  output logic [XLEN-1:0]  PCTargetB,
  output logic [CNT_W-1:0] RedirectCount
);

  localparam logic [1:0] SRC_NONE = 2'b00;
  localparam logic [1:0] SRC_REL  = 2'b01;
  localparam logic [1:0] SRC_JALR = 2'b10;

  logic [XLEN-1:0] pc_b, imm_b, src_a_b, src_b_b;
  logic [2:0]      funct3_b;
  logic            branch_b, jump_b, jalr_b;
  logic            cond;
  logic [XLEN-1:0] jalr_sum;

  // Pipeline register: data always loads, control fields bubble on flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      ValidB     <= 1'b0;
      ALUResultB <= '0;
      WriteDataB <= '0;
      PCPlus4B   <= '0;
      RdB        <= '0;
      RegWriteB  <= 1'b0;
      ResultSrcB <= '0;
      MemWriteB  <= 1'b0;
      pc_b       <= '0;
      imm_b      <= '0;
      src_a_b    <= '0;
      src_b_b    <= '0;
      funct3_b   <= '0;
      branch_b   <= 1'b0;
      jump_b     <= 1'b0;
      jalr_b     <= 1'b0;
    end else begin
      ALUResultB <= ALUResultE;
      WriteDataB <= WriteDataE;
      PCPlus4B   <= PCPlus4E;
      pc_b       <= PCE;
      imm_b      <= ImmExtE;
      src_a_b    <= SrcAE;
      src_b_b    <= SrcBE;
      funct3_b   <= Funct3E;
      if (FlushB) begin
        ValidB     <= 1'b0;
        RdB        <= '0;
        RegWriteB  <= 1'b0;
        ResultSrcB <= '0;
        MemWriteB  <= 1'b0;
        branch_b   <= 1'b0;
        jump_b     <= 1'b0;
        jalr_b     <= 1'b0;
      end else begin
        ValidB     <= ValidE;
        RdB        <= RdE;
        RegWriteB  <= RegWriteE;
        ResultSrcB <= ResultSrcE;
        MemWriteB  <= MemWriteE;
        branch_b   <= BranchE;
        jump_b     <= JumpE;
        jalr_b     <= JalrE;
      end
    end
  end

  // Branch condition evaluation.
  always_comb begin
    cond = 1'b0;
    case (funct3_b)
      3'b000:  cond = (src_a_b == src_b_b);
      3'b001:  cond = (src_a_b != src_b_b);
      3'b100:  cond = ($signed(src_a_b) <  $signed(src_b_b));
      3'b101:  cond = ($signed(src_a_b) >= $signed(src_b_b));
      3'b110:  cond = (src_a_b <  src_b_b);
      3'b111:  cond = (src_a_b >= src_b_b);
      default: cond = 1'b0;
    endcase
  end

  // Redirect select and target; JALR wins over JAL/branch.
  always_comb begin
    PCSrcB    = SRC_NONE;
    jalr_sum  = src_a_b + imm_b;
    PCTargetB = pc_b + imm_b;
    if (ValidB && jalr_b) begin
      PCSrcB    = SRC_JALR;
      PCTargetB = {jalr_sum[XLEN-1:1], 1'b0};
    end else if (ValidB && (jump_b || (branch_b && cond))) begin
      PCSrcB = SRC_REL;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      RedirectCount <= '0;
    end else if (PCSrcB != SRC_NONE) begin
      RedirectCount <= RedirectCount + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_stage.sv
// Directed bench for branch_stage with a 4-bit redirect counter to reach wrap quickly.
module tb_branch_stage;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset, FlushB, ValidE;
  logic [XLEN-1:0]  PCE, PCPlus4E, ImmExtE, SrcAE, SrcBE, ALUResultE, WriteDataE;
  logic [4:0]       RdE;
  logic             RegWriteE, MemWriteE, BranchE, JumpE, JalrE;
  logic [2:0]       ResultSrcE, Funct3E;
  logic             ValidB, RegWriteB, MemWriteB;
  logic [XLEN-1:0]  ALUResultB, WriteDataB, PCPlus4B, PCTargetB;
  logic [4:0]       RdB;
  logic [2:0]       ResultSrcB;
  logic [1:0]       PCSrcB;
  logic [CNT_W-1:0] RedirectCount;

  int checks = 0;
  int failures = 0;

  branch_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .FlushB(FlushB), .ValidE(ValidE),
    .PCE(PCE), .PCPlus4E(PCPlus4E), .ImmExtE(ImmExtE), .SrcAE(SrcAE), .SrcBE(SrcBE),
    .ALUResultE(ALUResultE), .WriteDataE(WriteDataE), .RdE(RdE), .RegWriteE(RegWriteE),
    .ResultSrcE(ResultSrcE), .MemWriteE(MemWriteE), .BranchE(BranchE), .JumpE(JumpE),
    .JalrE(JalrE), .Funct3E(Funct3E), .ValidB(ValidB), .ALUResultB(ALUResultB),
    .WriteDataB(WriteDataB), .PCPlus4B(PCPlus4B), .RdB(RdB), .RegWriteB(RegWriteB),
    .ResultSrcB(ResultSrcB), .MemWriteB(MemWriteB), .PCSrcB(PCSrcB), .PCTargetB(PCTargetB),
    .RedirectCount(RedirectCount)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one E-stage instruction; unlisted fields get fixed recognizable values.
  task automatic set_e(input logic v, input logic br, input logic jp, input logic jr,
                       input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] imm,
                       input logic [31:0] a, input logic [31:0] b);
    ValidE = v; BranchE = br; JumpE = jp; JalrE = jr; Funct3E = f3;
    PCE = pc; PCPlus4E = pc + 32'd4; ImmExtE = imm; SrcAE = a; SrcBE = b;
    ALUResultE = 32'hA5A5_0000 ^ pc; WriteDataE = 32'h0000_1234;
    RdE = 5'd3; RegWriteE = 1'b1; ResultSrcE = 3'b000; MemWriteE = 1'b0;
  endtask

  task automatic idle();
    set_e(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0);
    RegWriteE = 1'b0; RdE = 5'd0;
  endtask

  initial begin
    reset = 1'b1; FlushB = 1'b0;
    set_e(1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 32'h40, 32'h8, 32'h1, 32'h1);
    step(); step();
    check("rst_valid", 32'(ValidB), 32'd0);
    check("rst_regwrite", 32'(RegWriteB), 32'd0);
    check("rst_rd", 32'(RdB), 32'd0);
    check("rst_pcsrc", 32'(PCSrcB), 32'd0);
    check("rst_count", 32'(RedirectCount), 32'd0);

    reset = 1'b0; idle(); step();
    check("idle_valid", 32'(ValidB), 32'd0);

    // BEQ taken, then flush the younger instruction
    set_e(1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 32'h100, 32'h20, 32'd5, 32'd5); step();
    check("beq_valid", 32'(ValidB), 32'd1);
    check("beq_pcsrc", 32'(PCSrcB), 32'd1);
    check("beq_target", PCTargetB, 32'h120);
    check("beq_pcplus4", PCPlus4B, 32'h104);
    check("beq_alu", ALUResultB, 32'hA5A5_0100);
    FlushB = 1'b1;
    set_e(1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 32'h104, 32'h0, 32'h0, 32'h0); RdE = 5'd7; step();
    FlushB = 1'b0;
    check("flush_valid", 32'(ValidB), 32'd0);
    check("flush_rd", 32'(RdB), 32'd0);
    check("flush_regwrite", 32'(RegWriteB), 32'd0);
    check("flush_pcsrc", 32'(PCSrcB), 32'd0);
    check("beq_count", 32'(RedirectCount), 32'd1);

    // BNE with equal operands: not taken
    set_e(1'b1, 1'b1, 1'b0, 1'b0, 3'b001, 32'h200, 32'h40, 32'd9, 32'd9); step();
    check("bne_pcsrc", 32'(PCSrcB), 32'd0);
    check("bne_valid", 32'(ValidB), 32'd1);

    // BLT signed: -1 < 1 taken
    set_e(1'b1, 1'b1, 1'b0, 1'b0, 3'b100, 32'h300, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'd1); step();
    check("blt_pcsrc", 32'(PCSrcB), 32'd1);
    check("blt_target", PCTargetB, 32'h2F0);
    check("blt_count_before", 32'(RedirectCount), 32'd1);
    FlushB = 1'b1; idle(); step(); FlushB = 1'b0;
    check("blt_count", 32'(RedirectCount), 32'd2);

    // BLTU: 0xFFFFFFFF < 1 is false
    set_e(1'b1, 1'b1, 1'b0, 1'b0, 3'b110, 32'h300, 32'h10, 32'hFFFF_FFFF, 32'd1); step();
    check("bltu_pcsrc", 32'(PCSrcB), 32'd0);
    // BGE signed: 1 >= -1 taken
    set_e(1'b1, 1'b1, 1'b0, 1'b0, 3'b101, 32'h400, 32'h8, 32'd1, 32'hFFFF_FFFF); step();
    check("bge_pcsrc", 32'(PCSrcB), 32'd1);
    check("bge_target", PCTargetB, 32'h408);
    // BGEU: 1 >= 0xFFFFFFFF false
    set_e(1'b1, 1'b1, 1'b0, 1'b0, 3'b111, 32'h500, 32'h8, 32'd1, 32'hFFFF_FFFF); step();
    check("bgeu_pcsrc", 32'(PCSrcB), 32'd0);
    check("bge_count", 32'(RedirectCount), 32'd3);
    // Funct3 010 never branches even with equal operands
    set_e(1'b1, 1'b1, 1'b0, 1'b0, 3'b010, 32'h600, 32'h8, 32'd4, 32'd4); step();
    check("f010_pcsrc", 32'(PCSrcB), 32'd0);

    // JALR with Branch also set and cond true: JALR wins, bit0 cleared
    set_e(1'b1, 1'b1, 1'b0, 1'b1, 3'b000, 32'h700, 32'h4, 32'h1001, 32'h1001); step();
    check("jalr_pcsrc", 32'(PCSrcB), 32'd2);
    check("jalr_target", PCTargetB, 32'h1004);
    FlushB = 1'b1; idle(); step(); FlushB = 1'b0;
    check("jalr_count", 32'(RedirectCount), 32'd4);

    // JAL with PC+imm wrap-around
    set_e(1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 32'hFFFF_FFF0, 32'h20, 32'h0, 32'h0); step();
    check("jal_pcsrc", 32'(PCSrcB), 32'd1);
    check("jal_target", PCTargetB, 32'h10);
    check("jal_pcplus4", PCPlus4B, 32'hFFFF_FFF4);
    // Invalid slot with stale jump bits must not redirect or count
    set_e(1'b0, 1'b0, 1'b1, 1'b1, 3'b000, 32'h800, 32'h20, 32'h0, 32'h0); step();
    check("bubble_pcsrc", 32'(PCSrcB), 32'd0);
    check("jal_count", 32'(RedirectCount), 32'd5);
    idle(); step();
    check("bubble_count", 32'(RedirectCount), 32'd5);

    // Reset beats flush on the same edge
    reset = 1'b1; FlushB = 1'b1;
    set_e(1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 32'h900, 32'h4, 32'h0, 32'h0); RdE = 5'd7; step();
    reset = 1'b0; FlushB = 1'b0;
    check("rf_valid", 32'(ValidB), 32'd0);
    check("rf_pcsrc", 32'(PCSrcB), 32'd0);
    check("rf_alu", ALUResultB, 32'd0);
    check("rf_count", 32'(RedirectCount), 32'd0);

    // 16 back-to-back redirects wrap the 4-bit counter to zero
    for (int i = 0; i < 16; i++) begin
      set_e(1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 32'h1000 + 32'(i) * 32'd4, 32'h100, 32'h0, 32'h0);
      step();
    end
    check("wrap_count_15", 32'(RedirectCount), 32'd15);
    idle(); step();
    check("wrap_count_0", 32'(RedirectCount), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/branch_stage.md
Name: branch_stage

Overview:
- Execute→Branch pipeline register plus the branch/jump resolution logic of the 6-stage core.
- Captures Execute-stage results and controls each cycle, then resolves conditional branches, JAL and JALR in the B stage.
- Drives PCSrcB/PCTargetB to the fetch PC mux, and RdB/RegWriteB/ResultSrcB to the hazard unit and the B→M register.
- Takes FlushB from the hazard unit and keeps a wrapping count of redirects.

Parameters:
XLEN, 32, datapath width
CNT_W, 32, width of redirect counter

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
FlushB  in  1  bubble the B register on next edge
ValidE  in  1  E slot holds a real instruction
PCE  in  XLEN  PC of E instruction
PCPlus4E  in  XLEN  PC+4 of E instruction
ImmExtE  in  XLEN  sign-extended immediate
SrcAE  in  XLEN  forwarded rs1 value
SrcBE  in  XLEN  forwarded rs2 value (compare operand)
ALUResultE  in  XLEN  ALU result
WriteDataE  in  XLEN  store data
RdE  in  5  destination register
RegWriteE  in  1  writes register file
ResultSrcE  in  3  result select (3'b100 = load)
MemWriteE  in  1  store
BranchE  in  1  conditional branch
JumpE  in  1  JAL
JalrE  in  1  JALR
Funct3E  in  3  branch condition code
ValidB  out  1  B slot valid
ALUResultB  out  XLEN  registered ALU result
WriteDataB  out  XLEN  registered store data
PCPlus4B  out  XLEN  registered PC+4
RdB  out  5  registered rd
RegWriteB  out  1  registered RegWrite
ResultSrcB  out  3  registered ResultSrc
MemWriteB  out  1  registered MemWrite
PCSrcB  out  2  00 none, 01 PC-relative redirect, 10 JALR redirect
PCTargetB  out  XLEN  redirect target
RedirectCount  out  CNT_W  redirects taken since reset

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, port reset.
- Reset: all registered fields clear to 0 on the edge with reset=1. This covers ValidB, RegWriteB, MemWriteB, RdB, ResultSrcB, data fields and RedirectCount. PCSrcB is therefore 00 after reset.
- Priority per edge: reset > FlushB > load.
- Load (reset=0, FlushB=0): every E field is copied into its B register, including internal PCB, ImmB, SrcAB, SrcBB, Funct3B, BranchB, JumpB and JalrB. No B stall exists; the register loads every cycle.
- FlushB=1: the register loads a bubble. ValidB, RegWriteB, MemWriteB, BranchB, JumpB and JalrB become 0; RdB and ResultSrcB become 0. Data fields may hold any value.
- Latency: E→B is one cycle. PCSrcB/PCTargetB are combinational from B registers, so a redirect is visible in the same cycle the instruction occupies B.
- Flush timing: the hazard unit asserts FlushB in the cycle PCSrcB≠00. The resolving instruction therefore completes normally, and the younger instruction arriving from E is bubbled.
- Condition cond, computed on SrcAB vs SrcBB by Funct3B:
  - 000 eq, 001 ne
  - 100 signed lt, 101 signed ge
  - 110 unsigned lt, 111 unsigned ge
  - 010/011: cond=0
- PCSrcB encoding:
  - 10 if ValidB & JalrB
  - else 01 if ValidB & (JumpB | (BranchB & cond))
  - else 00
  - JALR has highest priority if multiple control bits are set.
- PCTargetB:
  - PCSrcB=10: (SrcAB + ImmB) with bit0 forced to 0
  - otherwise: PCB + ImmB
  - Addition is modulo 2^XLEN; wrap-around is silent.
- RedirectCount increments by 1 on each edge where reset=0 and PCSrcB≠00. It wraps from all-ones to 0.
- Bubble slot (ValidB=0): PCSrcB=00 regardless of stale data. Counter does not increment.
- JAL/JALR link value: supplied downstream via PCPlus4B and ResultSrcB; this block does not alter it.

Test Plan:
- Reset: hold reset 2 cycles with ValidE=1, RegWriteE=1 → after release edge, ValidB=0, RegWriteB=0, PCSrcB=00, RedirectCount=0.
- BEQ taken: SrcAE=SrcBE=5, Funct3E=000, BranchE=1, PCE=0x100, ImmExtE=0x20 → next cycle PCSrcB=01, PCTargetB=0x120. Drive FlushB=1 that cycle → following cycle ValidB=0, RedirectCount=1.
- BLT vs BLTU: SrcAE=0xFFFFFFFF, SrcBE=1 → Funct3=100 gives PCSrcB=01 (signed −1<1); Funct3=110 gives PCSrcB=00.
- JALR: SrcAE=0x1001, ImmExtE=0x4, JalrE=1, BranchE=1 → PCSrcB=10, PCTargetB=0x1004.
- Flush vs reset: FlushB=1 and reset=1 on the same edge → all outputs zero, counter 0. FlushB=1 alone with RegWriteE=1, RdE=7 → RdB=0, RegWriteB=0.
- Wrap: PCE=0xFFFFFFF0, ImmExtE=0x20, JumpE=1 → PCTargetB=0x10. Preload RedirectCount to all-ones (CNT_W=4 build) and take one redirect → count becomes 0.
